// File: rtl/ball_step_sequencer.sv
// ball_step_sequencer: owns ball position, bricks, lives and score, and paces the ball datapath one step per game tick.
// Optional pause support is compiled in when the macro PAUSE_EN is defined.
module ball_step_sequencer #(
    parameter int TICK_DIV     = 833333,
    parameter int NUM_BRICKS   = 12,
    parameter int LIVES        = 3,
    parameter int START_Y      = 30,
    parameter int LOST_Y       = 0,
    parameter int STEP_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  pause,
    input  logic [9:0]            paddle_location,
    output logic                  step_req,
    input  logic                  step_done,
    input  logic [9:0]            next_x,
    input  logic [9:0]            next_y,
    input  logic                  hit_valid,
    input  logic [3:0]            hit_num,
    output logic [9:0]            ball_x,
    output logic [9:0]            ball_y,
    output logic [NUM_BRICKS-1:0] brick_status,
    output logic [1:0]            lives,
    output logic [3:0]            score,
    output logic [2:0]            state,
    output logic                  step_err
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int TO_W   = $clog2(STEP_TIMEOUT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(STEP_TIMEOUT - 1);
    localparam logic [9:0]        RESET_X   = 10'd320;
    localparam logic [9:0]        START_Y_W = 10'(START_Y);
    localparam logic [9:0]        LOST_Y_W  = 10'(LOST_Y);
    localparam logic [1:0]        LIVES_W   = 2'(LIVES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        WAIT   = 3'd3,
        OVER   = 3'd4,
        WIN    = 3'd5,
        PAUSED = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic                    step_req_q, step_req_d;
    logic [9:0]              ball_x_q, ball_x_d;
    logic [9:0]              ball_y_q, ball_y_d;
    logic [NUM_BRICKS-1:0]   brick_status_q, brick_status_d;
    logic [1:0]              lives_q, lives_d;
    logic [3:0]              score_q, score_d;
    logic                    step_err_q, step_err_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]         wait_cnt_q, wait_cnt_d;

    logic                    tick;
    logic [NUM_BRICKS-1:0]   hit_mask;
    logic                    hit_any;
    logic [NUM_BRICKS-1:0]   status_after_hit;
    logic [3:0]              score_after_hit;
    logic [1:0]              lives_after_loss;
    logic                    ball_lost;

`ifndef PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause;
`endif

    // Free-running tick; a tick that PLAY does not consume is simply lost.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // One-hot brick clear: out-of-range indices and already-cleared bricks match nothing.
    generate
        for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_hit
            assign hit_mask[gi] = hit_valid && (int'(hit_num) == gi) && brick_status_q[gi];
        end
    endgenerate

    assign hit_any          = |hit_mask;
    assign status_after_hit = brick_status_q & ~hit_mask;
    assign score_after_hit  = (hit_any && score_q != 4'hF) ? score_q + 1'b1 : score_q;
    assign lives_after_loss = (lives_q != 2'd0) ? lives_q - 1'b1 : 2'd0;
    assign ball_lost        = (next_y <= LOST_Y_W);

    always_comb begin
        state_d        = state_q;
        step_req_d     = 1'b0;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        brick_status_d = brick_status_q;
        lives_d        = lives_q;
        score_d        = score_q;
        step_err_d     = step_err_q;
        wait_cnt_d     = wait_cnt_q;

        case (state_q)
            IDLE: begin
                ball_x_d       = RESET_X;
                ball_y_d       = START_Y_W;
                brick_status_d = '1;
                lives_d        = LIVES_W;
                score_d        = 4'd0;
                if (start) begin
                    state_d = SERVE;
                end
            end

            SERVE: begin
                ball_x_d = paddle_location;
                ball_y_d = START_Y_W;
                if (start) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
`ifdef PAUSE_EN
                if (pause) begin
                    state_d = PAUSED;
                end else
`endif
                if (tick) begin
                    state_d    = WAIT;
                    step_req_d = 1'b1;
                    wait_cnt_d = '0;
                end
            end

            WAIT: begin
                if (step_done) begin
                    ball_x_d       = next_x;
                    ball_y_d       = next_y;
                    brick_status_d = status_after_hit;
                    score_d        = score_after_hit;
                    if (status_after_hit == '0) begin
                        state_d = WIN;
                    end else if (ball_lost) begin
                        lives_d = lives_after_loss;
                        state_d = (lives_after_loss == 2'd0) ? OVER : SERVE;
                    end else begin
                        state_d = PLAY;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d    = PLAY;
                    step_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            OVER, WIN: begin
                if (start) begin
                    state_d        = IDLE;
                    ball_x_d       = RESET_X;
                    ball_y_d       = START_Y_W;
                    brick_status_d = '1;
                    lives_d        = LIVES_W;
                    score_d        = 4'd0;
                end
            end

`ifdef PAUSE_EN
            PAUSED: begin
                if (pause) begin
                    state_d = PLAY;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            step_req_q     <= 1'b0;
            ball_x_q       <= RESET_X;
            ball_y_q       <= START_Y_W;
            brick_status_q <= '1;
            lives_q        <= LIVES_W;
            score_q        <= 4'd0;
            step_err_q     <= 1'b0;
            tick_cnt_q     <= '0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            step_req_q     <= step_req_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            brick_status_q <= brick_status_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            step_err_q     <= step_err_d;
            tick_cnt_q     <= tick_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign step_req     = step_req_q;
    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign brick_status = brick_status_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign state        = state_q;
    assign step_err     = step_err_q;

endmodule

// File: tb/tb_ball_step_sequencer.sv
// Directed bench for ball_step_sequencer: expected commits are queued when step_done is driven and checked after the edge.
module tb_ball_step_sequencer;

    localparam int TICK = 40;
    localparam int NB   = 12;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_PAUSED = 3'd6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [9:0]    paddle_location = 10'd100;
    logic          step_req;
    logic          step_done = 1'b0;
    logic [9:0]    next_x = 10'd0;
    logic [9:0]    next_y = 10'd0;
    logic          hit_valid = 1'b0;
    logic [3:0]    hit_num = 4'd0;
    logic [9:0]    ball_x, ball_y;
    logic [NB-1:0] brick_status;
    logic [1:0]    lives;
    logic [3:0]    score;
    logic [2:0]    state;
    logic          step_err;

    typedef struct packed {
        logic [9:0]    x;
        logic [9:0]    y;
        logic [NB-1:0] st;
        logic [1:0]    lv;
        logic [3:0]    sc;
        logic [2:0]    fsm;
    } exp_t;

    exp_t sb_q[$];

    logic [9:0]    m_x, m_y;
    logic [NB-1:0] m_status;
    logic [1:0]    m_lives;
    logic [3:0]    m_score;
    logic [2:0]    m_state;
    logic          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    ball_step_sequencer #(
        .TICK_DIV(TICK), .NUM_BRICKS(NB), .LIVES(3),
        .START_Y(30), .LOST_Y(0), .STEP_TIMEOUT(15)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .pause(pause),
        .paddle_location(paddle_location), .step_req(step_req),
        .step_done(step_done), .next_x(next_x), .next_y(next_y),
        .hit_valid(hit_valid), .hit_num(hit_num), .ball_x(ball_x),
        .ball_y(ball_y), .brick_status(brick_status), .lives(lives),
        .score(score), .state(state), .step_err(step_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic m_defaults();
        m_x = 10'd320; m_y = 10'd30; m_status = '1;
        m_lives = 2'd3; m_score = 4'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, ball_x, m_x);
        chk({tag, ".y"}, ball_y, m_y);
        chk({tag, ".bricks"}, brick_status, m_status);
        chk({tag, ".lives"}, lives, m_lives);
        chk({tag, ".score"}, score, m_score);
        chk({tag, ".state"}, state, m_state);
        chk({tag, ".err"}, step_err, m_err);
    endtask

    // start pulse, with the model applying the state-dependent meaning of start
    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        case (m_state)
            S_IDLE:  m_state = S_SERVE;
            S_SERVE: begin m_x = paddle_location; m_y = 10'd30; m_state = S_PLAY; end
            S_OVER, S_WIN: begin m_defaults(); m_state = S_IDLE; end
            default: ;
        endcase
    endtask

    task automatic model_commit(input logic [9:0] nx, input logic [9:0] ny,
                                input logic hv, input logic [3:0] hn);
        m_x = nx;
        m_y = ny;
        if (hv && hn < NB) begin
            if (m_status[hn]) begin
                m_status[hn] = 1'b0;
                if (m_score != 4'hF) m_score = m_score + 1'b1;
            end
        end
        if (m_status == '0) m_state = S_WIN;
        else if (ny == 10'd0) begin
            if (m_lives != 2'd0) m_lives = m_lives - 1'b1;
            m_state = (m_lives == 2'd0) ? S_OVER : S_SERVE;
        end else m_state = S_PLAY;
    endtask

    task automatic wait_req(input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < TICK + 8) begin
            if (step_req === 1'b1) seen = 1'b1;
            else begin step(); n++; end
        end
        chk({tag, ".req_seen"}, seen, 1'b1);
        chk({tag, ".wait_state"}, state, S_WAIT);
    endtask

    task automatic do_step(input string tag, input logic [9:0] nx, input logic [9:0] ny,
                           input logic hv, input logic [3:0] hn);
        exp_t e;
        wait_req(tag);
        next_x = nx; next_y = ny; hit_valid = hv; hit_num = hn; step_done = 1'b1;
        model_commit(nx, ny, hv, hn);
        e.x = m_x; e.y = m_y; e.st = m_status; e.lv = m_lives; e.sc = m_score; e.fsm = m_state;
        sb_q.push_back(e);
        step();
        step_done = 1'b0; hit_valid = 1'b0;
        e = sb_q.pop_front();
        chk({tag, ".x"}, ball_x, e.x);
        chk({tag, ".y"}, ball_y, e.y);
        chk({tag, ".bricks"}, brick_status, e.st);
        chk({tag, ".lives"}, lives, e.lv);
        chk({tag, ".score"}, score, e.sc);
        chk({tag, ".state"}, state, e.fsm);
        chk({tag, ".req_low"}, step_req, 1'b0);
        $display("step %s: next=(%0d,%0d) hit=%0b/%0d -> ball=(%0d,%0d) bricks=%h lives=%0d score=%0d state=%0d",
                 tag, nx, ny, hv, hn, ball_x, ball_y, brick_status, lives, score, state);
    endtask

    initial begin
        int req_cnt;
        m_defaults();
        m_state = S_IDLE;
        m_err = 1'b0;

        // reset values, observed while reset is held
        step(); step();
        check_all("reset");
        chk("reset.req", step_req, 1'b0);
        resetn = 1'b1;
        step();
        check_all("idle");

        // serve tracks the paddle, then launch
        start_pulse();
        check_all("serve_enter");
        step();
        m_x = paddle_location;
        check_all("serve_track");
        paddle_location = 10'd150;
        step();
        m_x = 10'd150;
        check_all("serve_track2");
        start_pulse();
        check_all("launch");

        // first step, then start in PLAY is ignored
        do_step("first", 10'd321, 10'd31, 1'b0, 4'd0);
        start_pulse();
        check_all("start_in_play");

        // brick hits: fresh, repeated, out of range
        do_step("hit5", 10'd321, 10'd40, 1'b1, 4'd5);
        chk("hit5.mask", brick_status, 12'hFDF);
        do_step("hit5_again", 10'd322, 10'd41, 1'b1, 4'd5);
        do_step("hit13", 10'd323, 10'd42, 1'b1, 4'd13);
        chk("hit13.score", score, 4'd1);

        // three lost balls
        do_step("lost1", 10'd50, 10'd0, 1'b0, 4'd0);
        start_pulse();
        check_all("reserve1");
        do_step("lost2", 10'd51, 10'd0, 1'b0, 4'd0);
        start_pulse();
        do_step("lost3", 10'd52, 10'd0, 1'b0, 4'd0);
        chk("over.lives", lives, 2'd0);
        start_pulse();
        check_all("over_to_idle");
        chk("over_to_idle.bricks", brick_status, 12'hFFF);

        // clear every brick; final hit coincides with a lost ball
        start_pulse();
        step();
        m_x = paddle_location; m_y = 10'd30;
        start_pulse();
        for (int i = 0; i < NB - 1; i++) begin
            do_step($sformatf("clear%0d", i), 10'd200, 10'd100, 1'b1, 4'(i));
        end
        do_step("win", 10'd10, 10'd0, 1'b1, 4'd11);
        chk("win.state", state, S_WIN);
        chk("win.lives", lives, 2'd3);
        chk("win.score", score, 4'd12);
        start_pulse();
        check_all("win_to_idle");

        // step timeout
        start_pulse();
        step();
        m_x = paddle_location; m_y = 10'd30;
        start_pulse();
        wait_req("timeout");
        for (int i = 0; i < 14; i++) step();
        chk("timeout.still_wait", state, S_WAIT);
        chk("timeout.err_before", step_err, 1'b0);
        step(); step();
        m_state = S_PLAY;
        m_err = 1'b1;
        check_all("timeout");
        $display("timeout: state=%0d err=%0b ball=(%0d,%0d)", state, step_err, ball_x, ball_y);
        next_x = 10'd999; next_y = 10'd999; step_done = 1'b1;
        step();
        step_done = 1'b0;
        check_all("late_done");

`ifdef PAUSE_EN
        pause = 1'b1;
        step();
        pause = 1'b0;
        m_state = S_PAUSED;
        check_all("paused");
        req_cnt = 0;
        for (int i = 0; i < 3 * TICK; i++) begin
            step();
            if (step_req !== 1'b0) req_cnt++;
        end
        chk("paused.no_req", req_cnt, 0);
        chk("paused.state", state, S_PAUSED);
        pause = 1'b1;
        step();
        pause = 1'b0;
        m_state = S_PLAY;
        check_all("resumed");
        do_step("resume_step", 10'd77, 10'd88, 1'b0, 4'd0);
`else
        req_cnt = 0;
        pause = 1'b1;
        step();
        pause = 1'b0;
        if (step_req !== 1'b0) req_cnt++;
        chk("pause_ignored.state", state, S_PLAY);
        chk("pause_ignored.req", req_cnt, 0);
`endif

        // asynchronous reset in the middle of a step
        wait_req("midreset");
        #2;
        resetn = 1'b0;
        #1;
        m_defaults();
        m_state = S_IDLE;
        m_err = 1'b0;
        check_all("midreset");
        chk("midreset.req", step_req, 1'b0);
        step();
        resetn = 1'b1;
        next_x = 10'd5; next_y = 10'd6; step_done = 1'b1;
        step();
        step_done = 1'b0;
        check_all("post_reset_done");
        $display("midreset: state=%0d ball=(%0d,%0d)", state, ball_x, ball_y);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
